// File: rtl/cpu_controller.sv
// Instruction-sequencing controller for the simple RISC CPU: fetch, decode and the per-instruction
// datapath/memory control sequences. Moore outputs decode from the registered state only.
module cpu_controller #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic [3:0] vsel,
    output logic [2:0] nsel,
    output logic       asel,
    output logic       bsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       write,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       addr_sel,
    output logic       load_addr,
    output logic [1:0] mem_cmd,
    output logic       halted,
    output logic [4:0] state_dbg
);

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE, S_WIMM, S_GET_B, S_GET_A,
        S_ALU_MOV, S_ALU, S_WB, S_STATUS, S_LA, S_ADDR, S_LD_ADDR, S_MEM_RD,
        S_LDR_WB, S_GET_RD, S_STR_C, S_STR_MEM, S_HALT
    } state_t;

    // Instruction class captured in DECODE so later states never look at opcode/op again.
    typedef enum logic [2:0] {K_MOV, K_ALU, K_CMP, K_MVN, K_LDR, K_STR} kind_t;

    localparam logic [1:0] CNT_LAST = 2'(MEM_LAT - 1);
    localparam logic [1:0] MC_NONE  = 2'b00;
    localparam logic [1:0] MC_READ  = 2'b01;
    localparam logic [1:0] MC_WRITE = 2'b10;

    state_t     state_q, state_d;
    kind_t      kind_q, kind_d;
    logic [1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RST;
            kind_q  <= K_MOV;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = 2'd0;
        case (state_q)
            S_RST:       state_d = S_IF1;
            S_IF1: begin
                if (cnt_q == CNT_LAST) state_d = S_IF2;
                else                   cnt_d   = cnt_q + 2'd1;
            end
            S_IF2:       state_d = S_UPDATE_PC;
            S_UPDATE_PC: state_d = S_DECODE;
            S_DECODE: begin
                casez ({opcode, op})
                    5'b110_10: state_d = S_WIMM;
                    5'b110_00: begin state_d = S_GET_B; kind_d = K_MOV; end
                    5'b101_00,
                    5'b101_10: begin state_d = S_GET_B; kind_d = K_ALU; end
                    5'b101_01: begin state_d = S_GET_B; kind_d = K_CMP; end
                    5'b101_11: begin state_d = S_GET_B; kind_d = K_MVN; end
                    5'b011_00: begin state_d = S_LA;    kind_d = K_LDR; end
                    5'b100_00: begin state_d = S_LA;    kind_d = K_STR; end
                    5'b111_??: state_d = S_HALT;
                    default:   state_d = S_IF1;
                endcase
            end
            S_WIMM:      state_d = S_IF1;
            S_GET_B: begin
                if (kind_q == K_MOV)      state_d = S_ALU_MOV;
                else if (kind_q == K_MVN) state_d = S_ALU;
                else                      state_d = S_GET_A;
            end
            S_GET_A:     state_d = S_ALU;
            S_ALU_MOV:   state_d = S_WB;
            S_ALU:       state_d = (kind_q == K_CMP) ? S_STATUS : S_WB;
            S_WB:        state_d = S_IF1;
            S_STATUS:    state_d = S_IF1;
            S_LA:        state_d = S_ADDR;
            S_ADDR:      state_d = S_LD_ADDR;
            S_LD_ADDR:   state_d = (kind_q == K_LDR) ? S_MEM_RD : S_GET_RD;
            S_MEM_RD: begin
                if (cnt_q == CNT_LAST) state_d = S_LDR_WB;
                else                   cnt_d   = cnt_q + 2'd1;
            end
            S_LDR_WB:    state_d = S_IF1;
            S_GET_RD:    state_d = S_STR_C;
            S_STR_C:     state_d = S_STR_MEM;
            S_STR_MEM:   state_d = S_IF1;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_RST;
        endcase
    end

    always_comb begin
        vsel      = 4'b0000;
        nsel      = 3'b000;
        asel      = 1'b0;
        bsel      = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        write     = 1'b0;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        addr_sel  = 1'b0;
        load_addr = 1'b0;
        mem_cmd   = MC_NONE;
        halted    = 1'b0;
        case (state_q)
            S_RST:       begin reset_pc = 1'b1; load_pc = 1'b1; end
            S_IF1:       begin addr_sel = 1'b1; mem_cmd = MC_READ; end
            S_IF2:       begin addr_sel = 1'b1; mem_cmd = MC_READ; load_ir = 1'b1; end
            S_UPDATE_PC: load_pc = 1'b1;
            S_DECODE:    nsel = 3'b001;
            S_WIMM:      begin vsel = 4'b0100; nsel = 3'b001; write = 1'b1; end
            S_GET_B:     begin nsel = 3'b100; loadb = 1'b1; end
            S_GET_A:     begin nsel = 3'b001; loada = 1'b1; end
            S_ALU_MOV:   begin asel = 1'b1; loadc = 1'b1; end
            S_ALU:       loadc = 1'b1;
            S_WB:        begin vsel = 4'b0001; nsel = 3'b010; write = 1'b1; end
            S_STATUS:    loads = 1'b1;
            S_LA:        begin nsel = 3'b001; loada = 1'b1; end
            S_ADDR:      begin bsel = 1'b1; loadc = 1'b1; end
            S_LD_ADDR:   load_addr = 1'b1;
            S_MEM_RD:    mem_cmd = MC_READ;
            S_LDR_WB: begin
                mem_cmd = MC_READ;
                vsel    = 4'b1000;
                nsel    = 3'b010;
                write   = 1'b1;
            end
            S_GET_RD:    begin nsel = 3'b010; loadb = 1'b1; end
            S_STR_C:     begin asel = 1'b1; loadc = 1'b1; end
            S_STR_MEM:   mem_cmd = MC_WRITE;
            S_HALT:      halted = 1'b1;
            default:     ;
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: expected per-cycle control vectors are queued when an
// instruction is driven and compared against the DUT on each falling edge.
module tb_cpu_controller;

    // Packed control vector layout:
    // {vsel[3:0], nsel[2:0], asel, bsel, loada, loadb, loadc, loads, write,
    //  load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd[1:0], halted}
    localparam logic [21:0] VS_C   = 22'h1 << 18;
    localparam logic [21:0] VS_IMM = 22'h4 << 18;
    localparam logic [21:0] VS_MD  = 22'h8 << 18;
    localparam logic [21:0] NS_RN  = 22'h1 << 15;
    localparam logic [21:0] NS_RD  = 22'h2 << 15;
    localparam logic [21:0] NS_RM  = 22'h4 << 15;
    localparam logic [21:0] ASEL   = 22'h1 << 14;
    localparam logic [21:0] BSEL   = 22'h1 << 13;
    localparam logic [21:0] LDA    = 22'h1 << 12;
    localparam logic [21:0] LDB    = 22'h1 << 11;
    localparam logic [21:0] LDC    = 22'h1 << 10;
    localparam logic [21:0] LDS    = 22'h1 << 9;
    localparam logic [21:0] WR     = 22'h1 << 8;
    localparam logic [21:0] LDIR   = 22'h1 << 7;
    localparam logic [21:0] LDPC   = 22'h1 << 6;
    localparam logic [21:0] RSTPC  = 22'h1 << 5;
    localparam logic [21:0] ADRS   = 22'h1 << 4;
    localparam logic [21:0] LDADR  = 22'h1 << 3;
    localparam logic [21:0] MC_RD  = 22'h2;
    localparam logic [21:0] MC_WR  = 22'h4;
    localparam logic [21:0] HLT    = 22'h1;

    localparam logic [21:0] E_RST    = LDPC | RSTPC;
    localparam logic [21:0] E_IF1    = ADRS | MC_RD;
    localparam logic [21:0] E_IF2    = ADRS | MC_RD | LDIR;
    localparam logic [21:0] E_UPC    = LDPC;
    localparam logic [21:0] E_DEC    = NS_RN;
    localparam logic [21:0] E_WIMM   = VS_IMM | NS_RN | WR;
    localparam logic [21:0] E_GETB   = NS_RM | LDB;
    localparam logic [21:0] E_GETA   = NS_RN | LDA;
    localparam logic [21:0] E_ALUMOV = ASEL | LDC;
    localparam logic [21:0] E_ALU    = LDC;
    localparam logic [21:0] E_WB     = VS_C | NS_RD | WR;
    localparam logic [21:0] E_STAT   = LDS;
    localparam logic [21:0] E_LA     = NS_RN | LDA;
    localparam logic [21:0] E_ADDR   = BSEL | LDC;
    localparam logic [21:0] E_LDADR  = LDADR;
    localparam logic [21:0] E_MEMRD  = MC_RD;
    localparam logic [21:0] E_LDRWB  = MC_RD | VS_MD | NS_RD | WR;
    localparam logic [21:0] E_GETRD  = NS_RD | LDB;
    localparam logic [21:0] E_STRC   = ASEL | LDC;
    localparam logic [21:0] E_STRMEM = MC_WR;
    localparam logic [21:0] E_HALT   = HLT;

    typedef struct {
        string       tag;
        logic [21:0] v;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       sel3;

    logic [3:0] vsel1, vsel3;
    logic [2:0] nsel1, nsel3;
    logic       asel1, bsel1, loada1, loadb1, loadc1, loads1, write1, load_ir1;
    logic       load_pc1, reset_pc1, addr_sel1, load_addr1, halted1;
    logic       asel3, bsel3, loada3, loadb3, loadc3, loads3, write3, load_ir3;
    logic       load_pc3, reset_pc3, addr_sel3, load_addr3, halted3;
    logic [1:0] mem_cmd1, mem_cmd3;
    logic [4:0] sd1, sd3;
    logic [21:0] obs1, obs3;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    cpu_controller #(.MEM_LAT(1)) u1 (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op),
        .vsel(vsel1), .nsel(nsel1), .asel(asel1), .bsel(bsel1),
        .loada(loada1), .loadb(loadb1), .loadc(loadc1), .loads(loads1),
        .write(write1), .load_ir(load_ir1), .load_pc(load_pc1), .reset_pc(reset_pc1),
        .addr_sel(addr_sel1), .load_addr(load_addr1), .mem_cmd(mem_cmd1),
        .halted(halted1), .state_dbg(sd1)
    );

    cpu_controller #(.MEM_LAT(3)) u3 (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op),
        .vsel(vsel3), .nsel(nsel3), .asel(asel3), .bsel(bsel3),
        .loada(loada3), .loadb(loadb3), .loadc(loadc3), .loads(loads3),
        .write(write3), .load_ir(load_ir3), .load_pc(load_pc3), .reset_pc(reset_pc3),
        .addr_sel(addr_sel3), .load_addr(load_addr3), .mem_cmd(mem_cmd3),
        .halted(halted3), .state_dbg(sd3)
    );

    assign obs1 = {vsel1, nsel1, asel1, bsel1, loada1, loadb1, loadc1, loads1, write1,
                   load_ir1, load_pc1, reset_pc1, addr_sel1, load_addr1, mem_cmd1, halted1};
    assign obs3 = {vsel3, nsel3, asel3, bsel3, loada3, loadb3, loadc3, loads3, write3,
                   load_ir3, load_pc3, reset_pc3, addr_sel3, load_addr3, mem_cmd3, halted3};

    task automatic check(input string tag, input logic [21:0] got, input logic [21:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic push_exp(input string tag, input logic [21:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        q.push_back(e);
    endtask

    // Waits (bounded) until every queued expectation has been compared; returns just after
    // the rising edge that follows the last compared cycle.
    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            check("drain_timeout", 22'(q.size()), 22'd0);
            q.delete();
        end
    endtask

    task automatic fetch(input int lat);
        repeat (lat) push_exp("IF1", E_IF1);
        push_exp("IF2", E_IF2);
        push_exp("UPDATE_PC", E_UPC);
        push_exp("DECODE", E_DEC);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        push_exp("RST_low", E_RST);
        drain();
        reset = 1'b1;
        push_exp("RST_rel", E_RST);
        drain();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            check($sformatf("%s(st%0d)", e.tag, sel3 ? sd3 : sd1), sel3 ? obs3 : obs1, e.v);
        end
    end

    initial begin
        reset  = 1'b1;
        opcode = 3'b000;
        op     = 2'b00;
        sel3   = 1'b0;
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) push_exp("RST_low", E_RST);
        drain();
        reset = 1'b1;
        push_exp("RST_rel", E_RST);
        drain();

        opcode = 3'b110; op = 2'b10;
        fetch(1); push_exp("WIMM", E_WIMM);
        drain();

        opcode = 3'b110; op = 2'b00;
        fetch(1); push_exp("MOVR_GETB", E_GETB); push_exp("ALU_MOV", E_ALUMOV); push_exp("MOVR_WB", E_WB);
        drain();

        foreach (q[i]) ;
        for (int k = 0; k < 2; k++) begin
            opcode = 3'b101; op = (k == 0) ? 2'b00 : 2'b10;
            fetch(1);
            push_exp("ADD_GETB", E_GETB); push_exp("ADD_GETA", E_GETA);
            push_exp("ADD_ALU", E_ALU); push_exp("ADD_WB", E_WB);
            drain();
        end

        opcode = 3'b101; op = 2'b01;
        fetch(1);
        push_exp("CMP_GETB", E_GETB); push_exp("CMP_GETA", E_GETA);
        push_exp("CMP_ALU", E_ALU); push_exp("CMP_STATUS", E_STAT);
        drain();

        opcode = 3'b101; op = 2'b11;
        fetch(1); push_exp("MVN_GETB", E_GETB); push_exp("MVN_ALU", E_ALU); push_exp("MVN_WB", E_WB);
        drain();

        opcode = 3'b011; op = 2'b00;
        fetch(1);
        push_exp("LDR_LA", E_LA); push_exp("LDR_ADDR", E_ADDR); push_exp("LDR_LDADDR", E_LDADR);
        push_exp("LDR_MEMRD", E_MEMRD); push_exp("LDR_WB", E_LDRWB);
        drain();

        opcode = 3'b100; op = 2'b00;
        fetch(1);
        push_exp("STR_LA", E_LA); push_exp("STR_ADDR", E_ADDR); push_exp("STR_LDADDR", E_LDADR);
        push_exp("STR_GETRD", E_GETRD); push_exp("STR_C", E_STRC); push_exp("STR_MEM", E_STRMEM);
        drain();

        opcode = 3'b000; op = 2'b01;
        fetch(1);
        drain();

        opcode = 3'b111; op = 2'b01;
        fetch(1); push_exp("HALT", E_HALT);
        drain();
        for (int i = 0; i < 19; i++) begin
            opcode = 3'($urandom_range(0, 7));
            op     = 2'($urandom_range(0, 3));
            push_exp("HALT_hold", E_HALT);
            drain();
        end
        pulse_reset();

        // Reset arrives while STR_C is the current state: no WRITE cycle may follow.
        opcode = 3'b100; op = 2'b00;
        fetch(1);
        push_exp("ABT_LA", E_LA); push_exp("ABT_ADDR", E_ADDR);
        push_exp("ABT_LDADDR", E_LDADR); push_exp("ABT_GETRD", E_GETRD);
        drain();
        reset = 1'b0;
        push_exp("ABT_RST", E_RST);
        push_exp("ABT_RST2", E_RST);
        drain();
        reset = 1'b1;
        push_exp("ABT_REL", E_RST);
        drain();

        reset = 1'b0;
        sel3  = 1'b1;
        push_exp("L3_RST", E_RST);
        drain();
        reset = 1'b1;
        push_exp("L3_REL", E_RST);
        drain();

        opcode = 3'b011; op = 2'b00;
        fetch(3);
        push_exp("L3_LA", E_LA); push_exp("L3_ADDR", E_ADDR); push_exp("L3_LDADDR", E_LDADR);
        repeat (3) push_exp("L3_MEMRD", E_MEMRD);
        push_exp("L3_LDRWB", E_LDRWB);
        drain();

        opcode = 3'b110; op = 2'b10;
        fetch(3); push_exp("L3_WIMM", E_WIMM);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
